wb_write_arbiter: RTL and testbench

- Owns the single register-file write port (write enable, write number, write data) in the pipelined CPU.
- Merges two writer sources:
  - the pipeline WB stage, which always has priority and never stalls;
  - a multicycle execution unit (mul/div), which uses a valid/ready handshake.
- Queues multicycle results in a small FIFO and drains them into free write-port cycles.
- Publishes a pending-register mask so the ID stage can stall on registers that still have queued writes.

---
 rtl/wb_write_arbiter.sv | 107 ++++++++++
 tb/tb_wb_write_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: the pipeline WB stage always wins, multicycle
// results wait in a small FIFO and drain into idle write-port cycles.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wb_we,
  input  logic [4:0]    wb_wn,
  input  logic [31:0]   wb_d,
  input  logic          mc_valid,
  output logic          mc_ready,
  input  logic [4:0]    mc_wn,
  input  logic [31:0]   mc_d,
  output logic          rf_we,
  output logic [4:0]    rf_wn,
  output logic [31:0]   rf_d,
  output logic [31:0]   pend_mask,
  output logic [AW:0]   mc_count,
  output logic          waw_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [4:0]       wn_q [DEPTH];
  logic [31:0]      d_q  [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             waw_q;
  logic             wb_act;
  logic             push;
  logic             pop;
  logic [31:0]      pend;

  assign wb_act   = wb_we & (wb_wn != 5'd0);
  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign mc_ready = (count != FULL_CNT);
  // Results aimed at r0 complete the handshake but are never queued.
  assign push     = mc_valid & mc_ready & (mc_wn != 5'd0);
  assign pop      = ~wb_act & (count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
      waw_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + AW'(1);
        vld_q[wr_ptr]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + AW'(1);
        vld_q[rd_ptr]  <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (wb_act && pend[wb_wn])
        waw_q <= 1'b1;
    end
  end

  // Queue payload carries no reset; only entries flagged in vld_q are observed.
  always_ff @(posedge clk) begin
    if (push) begin
      wn_q[wr_ptr] <= mc_wn;
      d_q[wr_ptr]  <= mc_d;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i])
        pend[wn_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wn = 5'd0;
    rf_d  = 32'd0;
    if (wb_act) begin
      rf_we = 1'b1;
      rf_wn = wb_wn;
      rf_d  = wb_d;
    end else if (count != '0) begin
      rf_we = 1'b1;
      rf_wn = wn_q[rd_ptr];
      rf_d  = d_q[rd_ptr];
    end
  end

  assign pend_mask = pend;
  assign mc_count  = count;
  assign waw_err   = waw_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: table of WB-path vectors plus
// hand-written sequences for queueing, full, WAW and reset behaviour.
module tb_wb_write_arbiter;

  logic        clk;
  logic        resetn;
  logic        wb_we;
  logic [4:0]  wb_wn;
  logic [31:0] wb_d;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_wn;
  logic [31:0] mc_d;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic [31:0] pend_mask;
  logic [2:0]  mc_count;
  logic        waw_err;

  int checks = 0;
  int errors = 0;

  wb_write_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we(wb_we), .wb_wn(wb_wn), .wb_d(wb_d),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wn(mc_wn), .mc_d(mc_d),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
    .pend_mask(pend_mask), .mc_count(mc_count), .waw_err(waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        exp_we;
    logic [4:0]  exp_wn;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int idx;
  int ndrain;
  logic [4:0]  drained_wn [8];
  logic [31:0] drained_d  [8];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hA5A5A5A5, 1'b1, 5'd5,  32'hA5A5A5A5};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0};
    vecs[2] = '{1'b0, 5'd7,  32'h00001234, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 5'd31, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  32'h00000001};

    resetn = 1'b0; wb_we = 1'b0; wb_wn = '0; wb_d = '0;
    mc_valid = 1'b0; mc_wn = '0; mc_d = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_count", 32'(mc_count), 32'd0);
    chk("reset_ready", 32'(mc_ready), 32'd1);
    chk("reset_pend", pend_mask, 32'd0);
    chk("reset_waw", 32'(waw_err), 32'd0);
    resetn = 1'b1;
    tick();
    chk("idle_rf_we", 32'(rf_we), 32'd0);
    chk("idle_ready", 32'(mc_ready), 32'd1);
    chk("idle_count", 32'(mc_count), 32'd0);

    // WB-only path with an empty queue: output follows inputs combinationally.
    for (int i = 0; i < 5; i++) begin
      wb_we = vecs[i].we; wb_wn = vecs[i].wn; wb_d = vecs[i].d;
      #1;
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_wn", i), 32'(rf_wn), 32'(vecs[i].exp_wn));
      chk($sformatf("vec%0d_d", i), rf_d, vecs[i].exp_d);
      tick();
    end
    wb_we = 1'b0; wb_wn = '0; wb_d = '0;
    tick();

    // Single push with WB idle: written the cycle after acceptance.
    mc_valid = 1'b1; mc_wn = 5'd7; mc_d = 32'h1234;
    #1;
    chk("push7_ready", 32'(mc_ready), 32'd1);
    chk("push7_nobypass", 32'(rf_we), 32'd0);
    tick();
    mc_valid = 1'b0;
    #1;
    chk("push7_we", 32'(rf_we), 32'd1);
    chk("push7_wn", 32'(rf_wn), 32'd7);
    chk("push7_d", rf_d, 32'h1234);
    chk("push7_pend", pend_mask, 32'h80);
    tick();
    chk("push7_count_after", 32'(mc_count), 32'd0);
    chk("push7_pend_after", pend_mask, 32'd0);
    chk("push7_idle_after", 32'(rf_we), 32'd0);

    // WB busy for 6 cycles while the producer offers r1..r5.
    wb_we = 1'b1; wb_wn = 5'd20; wb_d = 32'hCAFE0000;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      mc_valid = (idx < 5); mc_wn = 5'(idx + 1); mc_d = 32'(100 + idx + 1);
      #1;
      chk($sformatf("busy%0d_rf_wn", c), 32'(rf_wn), 32'd20);
      if (c >= 4) begin
        chk($sformatf("busy%0d_ready", c), 32'(mc_ready), 32'd0);
        chk($sformatf("busy%0d_pend", c), pend_mask, 32'h1E);
      end
      if (mc_valid && mc_ready) idx++;
      tick();
    end
    chk("busy_accepts", 32'(idx), 32'd4);
    chk("busy_count", 32'(mc_count), 32'd4);
    wb_we = 1'b0; wb_wn = '0; wb_d = '0;
    ndrain = 0;
    for (int c = 0; c < 8; c++) begin
      mc_valid = (idx < 5); mc_wn = 5'(idx + 1); mc_d = 32'(100 + idx + 1);
      #1;
      if (c == 0) chk("first_drain_ready", 32'(mc_ready), 32'd0);
      if (rf_we && ndrain < 8) begin
        drained_wn[ndrain] = rf_wn;
        drained_d[ndrain]  = rf_d;
        ndrain++;
      end
      if (mc_valid && mc_ready) idx++;
      tick();
    end
    mc_valid = 1'b0;
    chk("drain_total", 32'(ndrain), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < ndrain) begin
        chk($sformatf("drain%0d_wn", k), 32'(drained_wn[k]), 32'(k + 1));
        chk($sformatf("drain%0d_d", k), drained_d[k], 32'(100 + k + 1));
      end
    end
    chk("drain_count_end", 32'(mc_count), 32'd0);

    // Two queued writes to r9, then a WB write to r9 raises waw_err.
    wb_we = 1'b1; wb_wn = 5'd20; wb_d = 32'h0;
    mc_valid = 1'b1; mc_wn = 5'd9; mc_d = 32'd1;
    tick();
    mc_d = 32'd2;
    tick();
    mc_valid = 1'b0;
    wb_wn = 5'd9; wb_d = 32'hFF;
    #1;
    chk("waw_rf_wn", 32'(rf_wn), 32'd9);
    chk("waw_rf_d", rf_d, 32'hFF);
    chk("waw_pend", pend_mask, 32'h200);
    chk("waw_before", 32'(waw_err), 32'd0);
    tick();
    wb_we = 1'b0; wb_wn = '0; wb_d = '0;
    #1;
    chk("waw_set", 32'(waw_err), 32'd1);
    chk("waw_drain1_wn", 32'(rf_wn), 32'd9);
    chk("waw_drain1_d", rf_d, 32'd1);
    tick();
    chk("waw_drain2_d", rf_d, 32'd2);
    chk("waw_drain2_pend", pend_mask, 32'h200);
    tick();
    chk("waw_pend_clear", pend_mask, 32'd0);
    chk("waw_sticky", 32'(waw_err), 32'd1);
    chk("waw_idle", 32'(rf_we), 32'd0);

    // Result targeting r0: handshake completes, nothing queued or written.
    mc_valid = 1'b1; mc_wn = 5'd0; mc_d = 32'h55;
    #1;
    chk("r0_ready", 32'(mc_ready), 32'd1);
    tick();
    mc_valid = 1'b0;
    #1;
    chk("r0_count", 32'(mc_count), 32'd0);
    chk("r0_rf_we", 32'(rf_we), 32'd0);
    chk("r0_pend", pend_mask, 32'd0);

    // Reach count 2, then push and pop in the same cycle.
    wb_we = 1'b1; wb_wn = 5'd20;
    mc_valid = 1'b1; mc_wn = 5'd3; mc_d = 32'h3;
    tick();
    mc_wn = 5'd4; mc_d = 32'h4;
    tick();
    chk("pp_count_pre", 32'(mc_count), 32'd2);
    wb_we = 1'b0; wb_wn = '0;
    mc_wn = 5'd6; mc_d = 32'h6;
    #1;
    chk("pp_pop_wn", 32'(rf_wn), 32'd3);
    tick();
    mc_valid = 1'b0;
    chk("pp_count_post", 32'(mc_count), 32'd2);
    chk("pp_pend", pend_mask, 32'h50);

    // Queue a third entry, then reset asynchronously mid-cycle.
    wb_we = 1'b1; wb_wn = 5'd20;
    mc_valid = 1'b1; mc_wn = 5'd8; mc_d = 32'h8;
    tick();
    mc_valid = 1'b0; wb_we = 1'b0; wb_wn = '0;
    chk("rst3_count_pre", 32'(mc_count), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst3_count", 32'(mc_count), 32'd0);
    chk("rst3_pend", pend_mask, 32'd0);
    chk("rst3_ready", 32'(mc_ready), 32'd1);
    chk("rst3_waw", 32'(waw_err), 32'd0);
    chk("rst3_rf_we", 32'(rf_we), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rst3_discarded", 32'(rf_we), 32'd0);
    chk("rst3_count_after", 32'(mc_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
